sram_mem_tester: RTL and testbench

Avalon-MM master traffic generator that sits directly upstream of `sram_controller` and drives its `mem_if` slave port. On command it writes a pattern over an address window, then reads the window back with pipelined reads and compares each returned word against the regenerated pattern. It records pass/fail status, error count and first failing address. It is used for bring-up and regression of the SRAM path.

---
 rtl/sram_tester_pkg.sv | 31 +++
 rtl/sram_pattern_gen.sv | 59 +++++
 rtl/sram_mem_tester.sv | 161 ++++++++++++++++
 tb/tb_sram_mem_tester.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_tester_pkg.sv
// Shared types and LFSR feedback constants for the SRAM memory tester.
// SRAM_TESTER_LFSR_EN selects whether the LFSR pattern is built into the generators.
package sram_tester_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WRITE = 3'd1,
      ST_READ  = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } tester_state_t;

   typedef enum logic {
      PAT_ADDR = 1'b0,
      PAT_LFSR = 1'b1
   } pattern_t;

   localparam logic [31:0] LFSR_TAPS_8  = 32'h0000_00B8;
   localparam logic [31:0] LFSR_TAPS_16 = 32'h0000_B400;
   localparam logic [31:0] LFSR_TAPS_32 = 32'h8020_0003;

   // Maximal-length Galois masks; any other width falls back to the 16-bit mask.
   function automatic logic [31:0] lfsr_taps(input int width);
      case (width)
         8:       return LFSR_TAPS_8;
         32:      return LFSR_TAPS_32;
         default: return LFSR_TAPS_16;
      endcase
   endfunction

endpackage

// File: rtl/sram_pattern_gen.sv
// Address/data sequence generator: address counts up from base, data is either the
// address itself or a Galois LFSR (only when SRAM_TESTER_LFSR_EN is defined).
module sram_pattern_gen
   import sram_tester_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              advance,
   input  logic [ADDR_W-1:0] base,
   input  logic [DATA_W-1:0] seed,
   input  logic              mode,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] data
);

   localparam int MIN_W = (DATA_W < ADDR_W) ? DATA_W : ADDR_W;
   localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] addr_data;

   // Load wins over advance so a reload on the last accepted beat restarts cleanly.
   always_ff @(posedge clk) begin
      if (rst)          addr_q <= '0;
      else if (load)    addr_q <= base;
      else if (advance) addr_q <= addr_q + ADDR_ONE;
   end

   always_comb begin
      addr_data = '0;
      addr_data[MIN_W-1:0] = addr_q[MIN_W-1:0];
   end

`ifdef SRAM_TESTER_LFSR_EN
   localparam logic [DATA_W-1:0] TAPS     = DATA_W'(lfsr_taps(DATA_W));
   localparam logic [DATA_W-1:0] DATA_ONE = 1;

   logic [DATA_W-1:0] lfsr_q;

   always_ff @(posedge clk) begin
      if (rst)          lfsr_q <= '0;
      else if (load)    lfsr_q <= (seed == '0) ? DATA_ONE : seed;
      else if (advance) lfsr_q <= lfsr_q[0] ? ((lfsr_q >> 1) ^ TAPS) : (lfsr_q >> 1);
   end

   assign data = (mode == PAT_LFSR) ? lfsr_q : addr_data;
`else
   logic unused_cfg;
   assign unused_cfg = ^{seed, mode};
   assign data = addr_data;
`endif

   assign addr = addr_q;

endmodule

// File: rtl/sram_mem_tester.sv
// Avalon-MM traffic generator: writes a pattern over a window, reads it back pipelined
// and checks it. SRAM_TESTER_LFSR_EN enables the LFSR pattern option.
module sram_mem_tester
   import sram_tester_pkg::*;
#(
   parameter int ADDR_W          = 16,
   parameter int DATA_W          = 16,
   parameter int MAX_OUTSTANDING = 4,
   parameter int ERR_CNT_W       = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   // Avalon-MM master: a command (write or read) is accepted in any cycle where it is
   // high and waitrequest is low; until then address/writedata/command hold steady.
   // Each readdatavalid returns one earlier accepted read, in order.
   output logic [ADDR_W-1:0]    mem_address,
   output logic                 mem_write,
   output logic [DATA_W-1:0]    mem_writedata,
   output logic                 mem_read,
   input  logic [DATA_W-1:0]    mem_readdata,
   input  logic                 mem_readdatavalid,
   input  logic                 mem_waitrequest,
   input  logic                 start_i,
   input  logic [ADDR_W-1:0]    base_i,
   input  logic [ADDR_W:0]      len_i,
   input  logic                 pattern_sel_i,
   input  logic [DATA_W-1:0]    seed_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 error_o,
   output logic [ERR_CNT_W-1:0] err_cnt_o,
   output logic [ADDR_W-1:0]    first_err_addr_o,
   output logic [2:0]           state_o
);

   localparam int OUT_W = 4;
   localparam logic [OUT_W-1:0]     OUT_MAX = OUT_W'(MAX_OUTSTANDING);
   localparam logic [ADDR_W:0]      LEN_ONE = 1;
   localparam logic [ERR_CNT_W-1:0] ERR_ONE = 1;

   tester_state_t state_q, state_d;

   logic [ADDR_W-1:0]    base_q;
   logic [ADDR_W:0]      len_q, wr_cnt_q, rd_cnt_q, last_idx;
   logic [DATA_W-1:0]    seed_q;
   pattern_t             mode_q;
   logic [OUT_W-1:0]     out_q, out_d;
   logic [ERR_CNT_W-1:0] err_cnt_q;
   logic                 error_q, done_q;
   logic [ADDR_W-1:0]    first_err_q;

   logic                 start_acc, wr_acc, rd_acc, rsp, last_wr, last_rd, mismatch;
   logic                 wgen_load, wgen_adv;
   logic [ADDR_W-1:0]    gen_base, chk_addr;
   logic [DATA_W-1:0]    gen_seed, chk_data;

   assign start_acc = (state_q == ST_IDLE) && start_i;
   assign wr_acc    = mem_write && !mem_waitrequest;
   assign rd_acc    = mem_read && !mem_waitrequest;
   assign rsp       = mem_readdatavalid && (out_q != '0);
   assign last_idx  = len_q - LEN_ONE;
   assign last_wr   = wr_acc && (wr_cnt_q == last_idx);
   assign last_rd   = rd_acc && (rd_cnt_q == last_idx);
   assign out_d     = out_q + OUT_W'(rd_acc) - OUT_W'(rsp);
   assign mismatch  = mem_readdata != chk_data;

   // The command-side generator serves writes, then is reloaded to replay the window for reads.
   assign gen_base  = start_acc ? base_i : base_q;
   assign gen_seed  = start_acc ? seed_i : seed_q;
   assign wgen_load = start_acc || last_wr;
   assign wgen_adv  = wr_acc || rd_acc;

   sram_pattern_gen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_wr_gen (
      .clk(clk_i), .rst(rst_i), .load(wgen_load), .advance(wgen_adv),
      .base(gen_base), .seed(gen_seed), .mode(mode_q),
      .addr(mem_address), .data(mem_writedata)
   );

   sram_pattern_gen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_chk_gen (
      .clk(clk_i), .rst(rst_i), .load(start_acc), .advance(rsp),
      .base(base_i), .seed(seed_i), .mode(mode_q),
      .addr(chk_addr), .data(chk_data)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // DRAIN looks at the post-update count so DONE lands on the edge closing the last response.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (start_i) state_d = (len_i == '0) ? ST_DONE : ST_WRITE;
         ST_WRITE: if (last_wr) state_d = ST_READ;
         ST_READ:  if (last_rd) state_d = ST_DRAIN;
         ST_DRAIN: if (out_d == '0) state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      mem_write = 1'b0;
      mem_read  = 1'b0;
      busy_o    = 1'b0;
      case (state_q)
         ST_WRITE: begin mem_write = 1'b1; busy_o = 1'b1; end
         ST_READ:  begin mem_read = (out_q < OUT_MAX); busy_o = 1'b1; end
         ST_DRAIN: busy_o = 1'b1;
         default:  ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         base_q      <= '0;
         len_q       <= '0;
         seed_q      <= '0;
         mode_q      <= PAT_ADDR;
         wr_cnt_q    <= '0;
         rd_cnt_q    <= '0;
         out_q       <= '0;
         err_cnt_q   <= '0;
         error_q     <= 1'b0;
         first_err_q <= '0;
         done_q      <= 1'b0;
      end else begin
         out_q <= out_d;
         if (start_acc) begin
            base_q   <= base_i;
            len_q    <= len_i;
            seed_q   <= seed_i;
            mode_q   <= pattern_t'(pattern_sel_i);
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
         end else begin
            if (wr_acc) wr_cnt_q <= wr_cnt_q + LEN_ONE;
            if (rd_acc) rd_cnt_q <= rd_cnt_q + LEN_ONE;
         end
         if (start_acc) begin
            err_cnt_q   <= '0;
            error_q     <= 1'b0;
            first_err_q <= '0;
         end else if (rsp && mismatch) begin
            if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + ERR_ONE;
            if (!error_q) first_err_q <= chk_addr;
            error_q <= 1'b1;
         end
         if (state_d == ST_DONE) done_q <= 1'b1;
         else if (start_acc)     done_q <= 1'b0;
      end
   end

   assign done_o           = done_q;
   assign error_o          = error_q;
   assign err_cnt_o        = err_cnt_q;
   assign first_err_addr_o = first_err_q;
   assign state_o          = state_q;

endmodule

// File: tb/tb_sram_mem_tester.sv
// Directed bench for sram_mem_tester with an Avalon slave model, command monitor and
// expected address/data queues; honours SRAM_TESTER_LFSR_EN for the expected pattern.
module tb_sram_mem_tester;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] mem_address, mem_writedata, mem_readdata;
   logic        mem_write, mem_read, mem_readdatavalid, mem_waitrequest;
   logic        start, pattern_sel;
   logic [15:0] base, seed;
   logic [16:0] len;
   logic        busy, done, error;
   logic [15:0] err_cnt, first_err_addr;
   logic [2:0]  state;

   always #5 clk = ~clk;

   sram_mem_tester #(.ADDR_W(16), .DATA_W(16), .MAX_OUTSTANDING(4), .ERR_CNT_W(16)) dut (
      .clk_i(clk), .rst_i(rst),
      .mem_address(mem_address), .mem_write(mem_write), .mem_writedata(mem_writedata),
      .mem_read(mem_read), .mem_readdata(mem_readdata),
      .mem_readdatavalid(mem_readdatavalid), .mem_waitrequest(mem_waitrequest),
      .start_i(start), .base_i(base), .len_i(len), .pattern_sel_i(pattern_sel), .seed_i(seed),
      .busy_o(busy), .done_o(done), .error_o(error), .err_cnt_o(err_cnt),
      .first_err_addr_o(first_err_addr), .state_o(state)
   );

   int n_cmp = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // slave model and monitor state
   logic [15:0] mem [0:65535];
   int          cyc = 0;
   int          lat = 2;
   bit          rand_wait = 1'b0;
   bit          flip_en = 1'b0;
   int          rsp_due[$];
   logic [15:0] rsp_addr[$];
   logic [15:0] resp_a;
   logic [15:0] exp_wa[$], exp_wd[$], exp_ra[$];
   int          out_model = 0;
   int          n_wr = 0, n_rd = 0, n_cmd = 0;
   int          start_cyc = -1, done_cyc = -1, last_rsp_cyc = -1;
   logic        prev_stall = 1'b0, prev_wr = 1'b0, prev_rd = 1'b0;
   logic [15:0] prev_addr = '0, prev_wdata = '0;

   initial begin
      mem_waitrequest   = 1'b0;
      mem_readdatavalid = 1'b0;
      mem_readdata      = '0;
      forever begin
         @(negedge clk);
         if (mem_read && !mem_waitrequest) begin
            rsp_due.push_back(cyc + lat);
            rsp_addr.push_back(mem_address);
         end
         if (mem_write && !mem_waitrequest) mem[mem_address] = mem_writedata;
         if (rst) begin
            out_model  = 0;
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               check("stall_addr", mem_address, prev_addr);
               check("stall_wdata", mem_writedata, prev_wdata);
               check("stall_write", mem_write, prev_wr);
               check("stall_read", mem_read, prev_rd);
            end
            if (mem_write || mem_read) begin
               n_cmd++;
               check("rw_excl", mem_write & mem_read, 0);
            end
            if (mem_write && !mem_waitrequest) begin
               n_wr++;
               if (exp_wa.size() == 0) check("wr_extra", 1, 0);
               else begin
                  check("wr_addr", mem_address, exp_wa.pop_front());
                  check("wr_data", mem_writedata, exp_wd.pop_front());
               end
            end
            if (mem_read && !mem_waitrequest) begin
               n_rd++;
               check("out_limit", out_model < 4, 1);
               if (exp_ra.size() == 0) check("rd_extra", 1, 0);
               else check("rd_addr", mem_address, exp_ra.pop_front());
            end
            if (mem_readdatavalid && out_model > 0) begin
               last_rsp_cyc = cyc;
               out_model--;
            end
            if (mem_read && !mem_waitrequest) out_model++;
            if (start) start_cyc = cyc;
            if (done && done_cyc < 0 && start_cyc >= 0 && cyc > start_cyc) done_cyc = cyc;
            prev_stall = (mem_write || mem_read) && mem_waitrequest;
            prev_addr  = mem_address;
            prev_wdata = mem_writedata;
            prev_wr    = mem_write;
            prev_rd    = mem_read;
         end
         @(posedge clk);
         #1;
         cyc++;
         mem_waitrequest   = rand_wait ? 1'($urandom_range(0, 1)) : 1'b0;
         mem_readdatavalid = 1'b0;
         mem_readdata      = '0;
         if (rsp_due.size() != 0 && rsp_due[0] <= cyc) begin
            resp_a = rsp_addr.pop_front();
            void'(rsp_due.pop_front());
            mem_readdatavalid = 1'b1;
            mem_readdata = mem[resp_a] ^ ((flip_en && (resp_a == 16'd5 || resp_a == 16'd9)) ? 16'h0001 : 16'h0000);
         end
      end
   end

   task automatic start_test(input logic [15:0] b, input int n, input logic sel, input logic [15:0] sd);
      logic [15:0] s, a;
      exp_wa.delete();
      exp_wd.delete();
      exp_ra.delete();
      s = (sd == 16'h0) ? 16'h0001 : sd;
      for (int i = 0; i < n; i++) begin
         a = b + 16'(i);
`ifdef SRAM_TESTER_LFSR_EN
         exp_wd.push_back(sel ? s : a);
`else
         exp_wd.push_back(a);
`endif
         exp_wa.push_back(a);
         exp_ra.push_back(a);
         s = s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
      end
      n_wr = 0; n_rd = 0; n_cmd = 0;
      start_cyc = -1; done_cyc = -1; last_rsp_cyc = -1;
      @(posedge clk);
      #1;
      start = 1'b1; base = b; len = 17'(n); pattern_sel = sel; seed = sd;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      if (n > 0) begin
         check("start_busy", busy, 1);
         check("start_write", mem_write, 1);
         check("start_addr", mem_address, b);
      end else begin
         check("len0_done", done, 1);
         check("len0_busy", busy, 0);
      end
   endtask

   task automatic finish_test(input int n, input int exp_err, input logic [15:0] exp_first);
      int guard;
      guard = 0;
      while (!done && guard < 3000) begin
         @(negedge clk);
         guard++;
      end
      check("done_seen", done, 1);
      check("busy_end", busy, 0);
      check("err_cnt", err_cnt, exp_err);
      check("error", error, exp_err != 0);
      check("first_err", first_err_addr, exp_first);
      check("n_writes", n_wr, n);
      check("n_reads", n_rd, n);
      check("exp_left", exp_wa.size() + exp_ra.size(), 0);
      if (n == 0) check("len0_cmd", n_cmd, 0);
      repeat (3) @(negedge clk);
      check("done_lat", done_cyc, (n == 0) ? start_cyc + 1 : last_rsp_cyc + 1);
      check("done_hold", done, 1);
      check("err_hold", err_cnt, exp_err);
   endtask

   initial begin
      int got3;
      start = 1'b0; base = '0; len = '0; pattern_sel = 1'b0; seed = '0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_write", mem_write, 0);
      check("rst_read", mem_read, 0);
      check("rst_addr", mem_address, 0);
      check("rst_wdata", mem_writedata, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_error", error, 0);
      check("rst_err_cnt", err_cnt, 0);
      check("rst_first", first_err_addr, 0);

      // ideal slave, address pattern
      start_test(16'h0000, 16, 1'b0, 16'h0000);
      finish_test(16, 0, 16'h0000);

      // bit 0 flipped at addresses 5 and 9
      flip_en = 1'b1;
      start_test(16'h0000, 16, 1'b0, 16'h0000);
      finish_test(16, 2, 16'h0005);
      flip_en = 1'b0;

      // empty window clears the previous error status
      start_test(16'h1234, 0, 1'b0, 16'h0000);
      finish_test(0, 0, 16'h0000);

      // random stalls with the LFSR pattern
      rand_wait = 1'b1;
      start_test(16'h0200, 64, 1'b1, 16'hACE1);
      finish_test(64, 0, 16'h0000);
      rand_wait = 1'b0;

      // window wrapping past the top of the address space
      start_test(16'hFFFE, 4, 1'b0, 16'h0000);
      finish_test(4, 0, 16'h0000);

      // reset in the middle of the read phase, with a longer slave latency
      lat = 4;
      start_test(16'h0100, 16, 1'b0, 16'h0000);
      got3 = 0;
      for (int i = 0; i < 300 && got3 == 0; i++) begin
         @(negedge clk);
         if (out_model == 3) got3 = 1;
      end
      check("rst_reach_3", got3, 1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("mid_rst_read", mem_read, 0);
      check("mid_rst_write", mem_write, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_done", done, 0);
      check("mid_rst_state", state, 0);
      repeat (8) @(negedge clk);
      check("late_rdv_err_cnt", err_cnt, 0);
      check("late_rdv_error", error, 0);
      check("late_rdv_done", done, 0);
      lat = 2;

      // clean pass after the reset
      start_test(16'h0100, 16, 1'b0, 16'h0000);
      finish_test(16, 0, 16'h0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
